sdram_ch_arbiter: RTL and testbench

Round-robin arbiter that shares one `sdram` controller channel (normally ch3, which has byte enables) between up to NUM_CLIENTS requesters, such as the CPU save-RAM path, the APF bridge loader and the cartridge EEPROM shadow. It converts each client's level request/acknowledge handshake into the controller's rising-edge `req` / one-cycle `ready` protocol. It holds address and data stable for the whole access and returns read data to the granted client. Optionally, it schedules opportunistic refreshes in idle gaps.

---
 rtl/sdram_arb_pkg.sv | 22 ++
 rtl/sdram_rr_picker.sv | 26 ++
 rtl/sdram_ch_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sdram_ch_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM channel arbiter and its picker.
// ST_RFSH_HOLD exists only when SDRAM_ARB_RFSH_EN is defined.
package sdram_arb_pkg;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 16;
  localparam int BE_W   = 2;

  typedef enum logic [2:0] {
    ST_QUIESCE,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
`ifdef SDRAM_ARB_RFSH_EN
    ST_DONE,
    ST_RFSH_HOLD
`else
    ST_DONE
`endif
  } arb_state_e;

endpackage

// File: rtl/sdram_rr_picker.sv
// Combinational round-robin picker: grants the first requester above last_grant,
// wrapping modulo N. Reusable by any front end that owns its own last_grant.
module sdram_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             valid,
  output logic [IDX_W-1:0] grant
);

  logic [IDX_W-1:0] idx;

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    valid = |req;
    grant = '0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IDX_W'((int'(last_grant) + k) % N);
      if (req[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/sdram_ch_arbiter.sv
// Round-robin arbiter sharing one sdram controller channel between NUM_CLIENTS
// level-handshake clients. Optional idle-gap refresh under SDRAM_ARB_RFSH_EN.
module sdram_ch_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CLIENTS    = 4,
  parameter int QUIESCE_CYCLES = 16,
  parameter int RFSH_INTERVAL  = 480,
  parameter int RFSH_HOLD      = 8
) (
  input  logic                        clk,
  input  logic                        init,
  input  logic [NUM_CLIENTS-1:0]      cl_req,
  input  logic [NUM_CLIENTS-1:0]      cl_rnw,
  input  logic [NUM_CLIENTS*26-1:0]   cl_addr,
  input  logic [NUM_CLIENTS*16-1:0]   cl_din,
  input  logic [NUM_CLIENTS*2-1:0]    cl_be,
  output logic [NUM_CLIENTS-1:0]      cl_ack,
  output logic [15:0]                 cl_rdata,
  output logic [25:0]                 sd_addr,
  output logic [15:0]                 sd_din,
  output logic [1:0]                  sd_be,
  output logic                        sd_rnw,
  output logic                        sd_req,
  input  logic [15:0]                 sd_dout,
  input  logic                        sd_ready,
  output logic                        do_refresh
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CNT_W = 16;

  if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || QUIESCE_CYCLES < 1 || RFSH_HOLD < 1 ||
      RFSH_INTERVAL < 1 || RFSH_INTERVAL > 1023) begin : g_bad_cfg
    $error("sdram_ch_arbiter: parameter out of range");
  end

  // Client handshake: cl_req is a level held until a one-cycle cl_ack; the
  // client drops it the cycle after, otherwise the IDLE that follows re-grants it.
  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [ADDR_W-1:0]  sd_addr_q, sd_addr_d;
  logic [DATA_W-1:0]  sd_din_q, sd_din_d;
  logic [BE_W-1:0]    sd_be_q, sd_be_d;
  logic               sd_rnw_q, sd_rnw_d;
  logic               sd_req_q, sd_req_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

`ifdef SDRAM_ARB_RFSH_EN
  logic [9:0]         rfsh_cnt_q, rfsh_cnt_d;
  logic               do_refresh_q, do_refresh_d;
`endif

  sdram_rr_picker #(.N(NUM_CLIENTS), .IDX_W(IDX_W)) u_picker (
    .req        (cl_req),
    .last_grant (last_q),
    .valid      (pick_valid),
    .grant      (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    last_d    = last_q;
    sd_addr_d = sd_addr_q;
    sd_din_d  = sd_din_q;
    sd_be_d   = sd_be_q;
    sd_rnw_d  = sd_rnw_q;
    sd_req_d  = 1'b0;
    rdata_d   = rdata_q;
`ifdef SDRAM_ARB_RFSH_EN
    do_refresh_d = 1'b0;
    rfsh_cnt_d   = (rfsh_cnt_q == '1) ? rfsh_cnt_q : rfsh_cnt_q + 10'd1;
`endif
    case (state_q)
      // Any sd_ready seen here belongs to an access aborted by init.
      ST_QUIESCE: begin
        if (cnt_q == CNT_W'(QUIESCE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d   = pick_idx;
          sd_addr_d = cl_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          sd_din_d  = cl_din[int'(pick_idx)*DATA_W +: DATA_W];
          sd_be_d   = cl_be[int'(pick_idx)*BE_W +: BE_W];
          sd_rnw_d  = cl_rnw[pick_idx];
          state_d   = ST_ISSUE;
        end
`ifdef SDRAM_ARB_RFSH_EN
        else if (rfsh_cnt_q >= 10'(RFSH_INTERVAL)) begin
          do_refresh_d = 1'b1;
          rfsh_cnt_d   = '0;
          cnt_d        = '0;
          state_d      = ST_RFSH_HOLD;
        end
`endif
      end
      ST_ISSUE: begin
        sd_req_d = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (sd_ready) begin
          if (sd_rnw_q) rdata_d = sd_dout;
          state_d = ST_DONE;
        end else begin
          sd_req_d = 1'b1;
        end
      end
      ST_DONE: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
`ifdef SDRAM_ARB_RFSH_EN
      ST_RFSH_HOLD: begin
        if (cnt_q == CNT_W'(RFSH_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = ST_QUIESCE;
    endcase
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q   <= ST_QUIESCE;
      cnt_q     <= '0;
      grant_q   <= '0;
      last_q    <= IDX_W'(NUM_CLIENTS - 1);
      sd_addr_q <= '0;
      sd_din_q  <= '0;
      sd_be_q   <= '0;
      sd_rnw_q  <= 1'b0;
      sd_req_q  <= 1'b0;
      rdata_q   <= '0;
`ifdef SDRAM_ARB_RFSH_EN
      rfsh_cnt_q   <= '0;
      do_refresh_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      sd_addr_q <= sd_addr_d;
      sd_din_q  <= sd_din_d;
      sd_be_q   <= sd_be_d;
      sd_rnw_q  <= sd_rnw_d;
      sd_req_q  <= sd_req_d;
      rdata_q   <= rdata_d;
`ifdef SDRAM_ARB_RFSH_EN
      rfsh_cnt_q   <= rfsh_cnt_d;
      do_refresh_q <= do_refresh_d;
`endif
    end
  end

  assign cl_ack   = (state_q == ST_DONE) ? (NUM_CLIENTS'(1) << grant_q) : '0;
  assign cl_rdata = rdata_q;
  assign sd_addr  = sd_addr_q;
  assign sd_din   = sd_din_q;
  assign sd_be    = sd_be_q;
  assign sd_rnw   = sd_rnw_q;
  assign sd_req   = sd_req_q;
`ifdef SDRAM_ARB_RFSH_EN
  assign do_refresh = do_refresh_q;
`else
  assign do_refresh = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_ch_arbiter.sv
// Directed bench for sdram_ch_arbiter with a small latency model of the sdram channel.
module tb_sdram_ch_arbiter;

  localparam int NC = 4;

  logic              clk = 1'b0;
  logic              init = 1'b1;
  logic [NC-1:0]     cl_req = '0;
  logic [NC-1:0]     cl_rnw = '0;
  logic [NC*26-1:0]  cl_addr = '0;
  logic [NC*16-1:0]  cl_din = '0;
  logic [NC*2-1:0]   cl_be = '0;
  logic [NC-1:0]     cl_ack;
  logic [15:0]       cl_rdata;
  logic [25:0]       sd_addr;
  logic [15:0]       sd_din;
  logic [1:0]        sd_be;
  logic              sd_rnw;
  logic              sd_req;
  logic [15:0]       sd_dout = '0;
  logic              sd_ready = 1'b0;
  logic              do_refresh;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  sdram_ch_arbiter #(
    .NUM_CLIENTS(NC), .QUIESCE_CYCLES(16), .RFSH_INTERVAL(20), .RFSH_HOLD(8)
  ) dut (
    .clk(clk), .init(init), .cl_req(cl_req), .cl_rnw(cl_rnw), .cl_addr(cl_addr),
    .cl_din(cl_din), .cl_be(cl_be), .cl_ack(cl_ack), .cl_rdata(cl_rdata),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_be(sd_be), .sd_rnw(sd_rnw),
    .sd_req(sd_req), .sd_dout(sd_dout), .sd_ready(sd_ready), .do_refresh(do_refresh)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Channel model: ready arrives rd_lat/wr_lat negedges after the req edge is seen.
  int          rd_lat = 9;
  int          wr_lat = 3;
  logic [15:0] model_rdata = '0;
  logic        req_prev = 1'b0;
  logic        mbusy = 1'b0;
  int          mcnt = 0;
  logic [15:0] mdata = '0;
  int          ready_cyc = 0;
  int          req_rises = 0;

  always @(negedge clk) begin
    sd_ready = 1'b0;
    if (sd_req && !req_prev) begin
      req_rises++;
      mbusy = 1'b1;
      mcnt  = sd_rnw ? rd_lat : wr_lat;
      mdata = model_rdata;
    end else if (mbusy) begin
      mcnt--;
      if (mcnt == 0) begin
        mbusy     = 1'b0;
        sd_ready  = 1'b1;
        sd_dout   = mdata;
        ready_cyc = cyc;
      end
    end
    req_prev = sd_req;
  end

  task automatic set_client(input int c, input logic rnw, input logic [25:0] a,
                            input logic [15:0] d, input logic [1:0] be);
    cl_rnw[c]          = rnw;
    cl_addr[26*c +: 26] = a;
    cl_din[16*c +: 16]  = d;
    cl_be[2*c +: 2]     = be;
  endtask

  task automatic test_reset();
    int first_req = 0;
    int first_ack = 0;
    logic [NC-1:0] ack_v = '0;
    init = 1'b1;
    set_client(0, 1'b0, 26'h0000ABC, 16'h1111, 2'b11);
    cl_req = 4'b0001;
    repeat (3) @(negedge clk);
    n_cmp++; if (cl_ack !== '0) begin n_bad++; $display("FAIL rst_cl_ack: got %0h expected 0", cl_ack); end
    n_cmp++; if (cl_rdata !== '0) begin n_bad++; $display("FAIL rst_cl_rdata: got %0h expected 0", cl_rdata); end
    n_cmp++; if (sd_addr !== '0) begin n_bad++; $display("FAIL rst_sd_addr: got %0h expected 0", sd_addr); end
    n_cmp++; if (sd_din !== '0) begin n_bad++; $display("FAIL rst_sd_din: got %0h expected 0", sd_din); end
    n_cmp++; if (sd_be !== '0) begin n_bad++; $display("FAIL rst_sd_be: got %0h expected 0", sd_be); end
    n_cmp++; if (sd_rnw !== 1'b0) begin n_bad++; $display("FAIL rst_sd_rnw: got %0b expected 0", sd_rnw); end
    n_cmp++; if (sd_req !== 1'b0) begin n_bad++; $display("FAIL rst_sd_req: got %0b expected 0", sd_req); end
    n_cmp++; if (do_refresh !== 1'b0) begin n_bad++; $display("FAIL rst_do_refresh: got %0b expected 0", do_refresh); end
    init = 1'b0;
    for (int k = 1; k <= 40 && first_ack == 0; k++) begin
      @(negedge clk);
      if (sd_req && first_req == 0) first_req = k;
      if (|cl_ack) begin first_ack = k; ack_v = cl_ack; cl_req = '0; end
    end
    n_cmp++; if (first_req != 18) begin n_bad++; $display("FAIL quiesce_first_req: got %0d expected 18", first_req); end
    n_cmp++; if (first_ack != 22) begin n_bad++; $display("FAIL first_write_ack_cycle: got %0d expected 22", first_ack); end
    n_cmp++; if (ack_v !== 4'b0001) begin n_bad++; $display("FAIL first_write_ack: got %0b expected 0001", ack_v); end
    n_cmp++; if (sd_addr !== 26'h0000ABC) begin n_bad++; $display("FAIL first_write_addr: got %0h expected abc", sd_addr); end
  endtask

  task automatic test_single_read();
    int lat = 0;
    int extra = 0;
    int rises0;
    logic [NC-1:0] ack_v = '0;
    logic [15:0] rd_v = '0;
    repeat (2) @(negedge clk);
    rises0 = req_rises;
    set_client(1, 1'b1, 26'h0000123, 16'h0000, 2'b11);
    model_rdata = 16'hBEEF;
    rd_lat = 9;
    cl_req[1] = 1'b1;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (|cl_ack) begin lat = k; ack_v = cl_ack; rd_v = cl_rdata; cl_req[1] = 1'b0; end
    end
    repeat (6) begin
      @(negedge clk);
      if (|cl_ack) extra++;
    end
    n_cmp++; if (lat != 12) begin n_bad++; $display("FAIL read_latency: got %0d expected 12", lat); end
    n_cmp++; if (ack_v !== 4'b0010) begin n_bad++; $display("FAIL read_ack: got %0b expected 0010", ack_v); end
    n_cmp++; if (rd_v !== 16'hBEEF) begin n_bad++; $display("FAIL read_data: got %0h expected beef", rd_v); end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL read_extra_acks: got %0d expected 0", extra); end
    n_cmp++; if (req_rises - rises0 != 1) begin n_bad++; $display("FAIL read_req_edges: got %0d expected 1", req_rises - rises0); end
    n_cmp++; if (cl_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL read_data_hold: got %0h expected beef", cl_rdata); end
  endtask

  task automatic test_byte_write();
    int lat = 0;
    int bad_samples = 0;
    int ack_cyc = 0;
    logic [NC-1:0] ack_v = '0;
    repeat (2) @(negedge clk);
    set_client(2, 1'b0, 26'h3FFFFFF, 16'hA55A, 2'b10);
    cl_req[2] = 1'b1;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (sd_be !== 2'b10 || sd_din !== 16'hA55A || sd_addr !== 26'h3FFFFFF || sd_rnw !== 1'b0)
        bad_samples++;
      if (|cl_ack) begin lat = k; ack_v = cl_ack; ack_cyc = cyc; cl_req[2] = 1'b0; end
    end
    n_cmp++; if (bad_samples != 0) begin n_bad++; $display("FAIL bw_stable: got %0d unstable cycles expected 0", bad_samples); end
    n_cmp++; if (ack_v !== 4'b0100) begin n_bad++; $display("FAIL bw_ack: got %0b expected 0100", ack_v); end
    n_cmp++; if (lat != 6) begin n_bad++; $display("FAIL bw_latency: got %0d expected 6", lat); end
    n_cmp++; if (ack_cyc != ready_cyc + 1) begin n_bad++; $display("FAIL bw_ready_to_ack: got %0d expected %0d", ack_cyc, ready_cyc + 1); end
    n_cmp++; if (cl_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL bw_rdata_kept: got %0h expected beef", cl_rdata); end
  endtask

  task automatic test_back_to_back();
    int ack_at[3] = '{0, 0, 0};
    int n_ack = 0;
    int bad_ack = 0;
    repeat (2) @(negedge clk);
    set_client(0, 1'b0, 26'h0000001, 16'h0F0F, 2'b01);
    cl_req[0] = 1'b1;
    for (int k = 1; k <= 60 && n_ack < 3; k++) begin
      @(negedge clk);
      if (|cl_ack) begin
        if (cl_ack !== 4'b0001) bad_ack++;
        ack_at[n_ack] = k;
        n_ack++;
        if (n_ack == 3) cl_req[0] = 1'b0;
      end
    end
    n_cmp++; if (n_ack != 3) begin n_bad++; $display("FAIL b2b_count: got %0d expected 3", n_ack); end
    n_cmp++; if (bad_ack != 0) begin n_bad++; $display("FAIL b2b_ack_client: got %0d wrong acks expected 0", bad_ack); end
    n_cmp++; if (ack_at[0] != 6) begin n_bad++; $display("FAIL b2b_first: got %0d expected 6", ack_at[0]); end
    n_cmp++; if (ack_at[1] - ack_at[0] != 7) begin n_bad++; $display("FAIL b2b_gap1: got %0d expected 7", ack_at[1] - ack_at[0]); end
    n_cmp++; if (ack_at[2] - ack_at[1] != 7) begin n_bad++; $display("FAIL b2b_gap2: got %0d expected 7", ack_at[2] - ack_at[1]); end
  endtask

  task automatic test_fairness();
    int cnt[NC] = '{0, 0, 0, 0};
    int total = 0;
    int exp_c = 1;
    int c;
    logic [NC-1:0] one = 4'b0001;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NC; i++) set_client(i, 1'b0, 26'(32'h100 + i), 16'(32'hC000 + i), 2'b11);
    cl_req = 4'b1111;
    for (int k = 1; k <= 400 && total < 32; k++) begin
      @(negedge clk);
      if (|cl_ack) begin
        n_cmp++;
        if (cl_ack !== (one << exp_c)) begin
          n_bad++;
          $display("FAIL fair_grant: got %0b expected %0b (access %0d)", cl_ack, one << exp_c, total);
        end
        c = 0;
        for (int i = 0; i < NC; i++) if (cl_ack[i]) c = i;
        cnt[c]++;
        total++;
        exp_c = (exp_c + 1) % NC;
        for (int i = 0; i < NC; i++) cl_req[i] = (cnt[i] < 8) && (i != c);
      end
    end
    cl_req = '0;
    n_cmp++; if (total != 32) begin n_bad++; $display("FAIL fair_total: got %0d expected 32", total); end
  endtask

  task automatic test_reset_mid_wait();
    int s = 0;
    int first_req = 0;
    int first_ack = 0;
    logic [NC-1:0] ack_v = '0;
    logic [15:0] rd_v = '0;
    logic [15:0] rd_quiesce = '0;
    repeat (2) @(negedge clk);
    set_client(3, 1'b1, 26'h2000000, 16'h0000, 2'b11);
    model_rdata = 16'hDEAD;
    rd_lat = 7;
    cl_req[3] = 1'b1;
    for (int k = 1; k <= 20 && s == 0; k++) begin
      @(negedge clk);
      if (sd_req) s = k;
    end
    n_cmp++; if (s != 2) begin n_bad++; $display("FAIL rmw_issue: got %0d expected 2", s); end
    repeat (2) @(negedge clk);
    init = 1'b1;
    #1;
    n_cmp++; if (sd_req !== 1'b0) begin n_bad++; $display("FAIL rmw_req_drop: got %0b expected 0", sd_req); end
    n_cmp++; if (cl_ack !== '0) begin n_bad++; $display("FAIL rmw_ack_on_init: got %0b expected 0", cl_ack); end
    rd_lat = 9;
    model_rdata = 16'h1234;
    @(negedge clk);
    init = 1'b0;
    for (int k = 1; k <= 50 && first_ack == 0; k++) begin
      @(negedge clk);
      if (sd_req && first_req == 0) first_req = k;
      if (k == 12) rd_quiesce = cl_rdata;
      if (|cl_ack) begin first_ack = k; ack_v = cl_ack; rd_v = cl_rdata; cl_req[3] = 1'b0; end
    end
    n_cmp++; if (first_req != 18) begin n_bad++; $display("FAIL rmw_reissue: got %0d expected 18", first_req); end
    n_cmp++; if (first_ack != 28) begin n_bad++; $display("FAIL rmw_first_ack: got %0d expected 28", first_ack); end
    n_cmp++; if (ack_v !== 4'b1000) begin n_bad++; $display("FAIL rmw_ack: got %0b expected 1000", ack_v); end
    n_cmp++; if (rd_quiesce !== 16'h0000) begin n_bad++; $display("FAIL rmw_orphan_data: got %0h expected 0", rd_quiesce); end
    n_cmp++; if (rd_v !== 16'h1234) begin n_bad++; $display("FAIL rmw_rdata: got %0h expected 1234", rd_v); end
  endtask

`ifdef SDRAM_ARB_RFSH_EN
  task automatic test_refresh();
    int r1 = 0, r2 = 0, rcount = 0;
    int s1 = 0, s2 = 0;
    logic prev_s = 1'b0;
    init = 1'b1;
    cl_req = '0;
    repeat (2) @(negedge clk);
    init = 1'b0;
    set_client(0, 1'b0, 26'h0000055, 16'h7777, 2'b11);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (do_refresh) begin
        rcount++;
        if (r1 == 0) r1 = k; else if (r2 == 0) r2 = k;
      end
      if (sd_req && !prev_s) begin
        if (s1 == 0) s1 = k; else if (s2 == 0) s2 = k;
      end
      prev_s = sd_req;
      if (|cl_ack) cl_req[0] = 1'b0;
      if (k == 22 || k == 41) cl_req[0] = 1'b1;
    end
    n_cmp++; if (rcount != 2) begin n_bad++; $display("FAIL rfsh_count: got %0d expected 2", rcount); end
    n_cmp++; if (r1 != 21) begin n_bad++; $display("FAIL rfsh_first: got %0d expected 21", r1); end
    n_cmp++; if (s1 != 31) begin n_bad++; $display("FAIL rfsh_hold_grant: got %0d expected 31", s1); end
    n_cmp++; if (s2 != 43) begin n_bad++; $display("FAIL rfsh_req_wins: got %0d expected 43", s2); end
    n_cmp++; if (r2 != 49) begin n_bad++; $display("FAIL rfsh_deferred: got %0d expected 49", r2); end
  endtask
`else
  task automatic test_refresh();
    int rcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (do_refresh) rcount++;
    end
    n_cmp++; if (rcount != 0) begin n_bad++; $display("FAIL no_refresh: got %0d pulses expected 0", rcount); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SDRAM_ARB_RFSH_EN
    test_refresh();
`else
    test_single_read();
    test_byte_write();
    test_back_to_back();
    test_fairness();
    test_reset_mid_wait();
    test_refresh();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
